spi_target: RTL and testbench
=============================

# spi_target

SPI target (slave) peripheral: the responder end of the SPI link our `spicore` drives as initiator. An external SPI host clocks bytes in on `spi_mosi` while the block simultaneously returns CPU-supplied bytes on `spi_miso`. The block sits on the FemtoRV32 memory bus as a memory-mapped device beside the UART and `spicore`. It oversamples the SPI pins with the system clock, so no SPI-clock-domain logic exists.

## Interface
- `IDLE_FILL`, 8'hFF, byte shifted out when no TX byte is pending.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `we`  in  1  one-cycle strobe: write `tx_data` into the TX holding register.
- `tx_data`  in  8  byte to send to the host.
- `rd`  in  1  one-cycle strobe: CPU has read `rx_data`; clears `rx_valid` and `overrun`.
- `rx_data`  out  8  last complete byte received.
- `rx_valid`  out  1  `rx_data` holds an unread byte.
- `overrun`  out  1  sticky: a byte completed while `rx_valid` was 1.
- `tx_empty`  out  1  TX holding register free.
- `busy`  out  1  synchronized `spi_ss` is low (transfer in progress).
- `spi_clk`  in  1  host SCK, asynchronous.
- `spi_ss`  in  1  host chip select, active low, asynchronous.
- `spi_mosi`  in  1  host data out, asynchronous.
- `spi_miso`  out  1  data to host, MSB first.
- `spi_miso_oe`  out  1  MISO output enable; equals `busy`.

## Operation
- Input sync: `spi_clk`, `spi_ss`, `spi_mosi` each pass through a 2-flop synchronizer, plus one history flop on SCK and SS for edge detection. All three share equal delay, so MOSI is sampled coherently with its SCK edge.
- State machine:
  - IDLE: entered on reset or when SS is high.
  - ACTIVE: entered on the detected SS falling edge.
- Entry to ACTIVE:
  - `bit_cnt` <= 0.
  - TX shift register <= `tx_hold` if `tx_empty`=0, else `IDLE_FILL`.
  - `tx_empty` <= 1.
- Rising SCK edge, ACTIVE:
  - `rx_shift` <= {`rx_shift[6:0]`, mosi_sync}; `bit_cnt`++.
  - On the 8th edge (`bit_cnt`=7→0): `rx_data` <= completed byte, `rx_valid` <= 1. If `rx_valid` was already 1 and no `rd` occurs this cycle, `overrun` <= 1.
  - Same 8th edge: TX shift register reloads from `tx_hold`/`IDLE_FILL`, `tx_empty` <= 1.
- Falling SCK edge, ACTIVE:
  - `bit_cnt` in 1..7: TX shift register shifts left one bit.
  - `bit_cnt`=0: no action. This rule lets SPI mode 0 and mode 3 both work without a parameter.
- `spi_miso` = TX shift register bit 7 while ACTIVE, 0 in IDLE.
- SS rising mid-byte: return to IDLE; partial RX byte discarded; `rx_data`/`rx_valid` unchanged; `bit_cnt` <= 0. The already-loaded TX byte is lost; `tx_hold` is unaffected.
- `we`: `tx_hold` <= `tx_data`, `tx_empty` <= 0; a write while full overwrites (last write wins).
- `we` on the same cycle as a load: the load uses the pre-write `tx_hold` value (fill byte if it was empty). The written byte is retained with `tx_empty`=0.
- `rd`: `rx_valid` <= 0, `overrun` <= 0. If `rd` coincides with a byte completion, completion wins: `rx_valid`=1, `overrun` unchanged.

## Timing
- Reset values:
  - `rx_data`=0, `rx_valid`=0, `overrun`=0, `tx_empty`=1, `busy`=0.
  - `spi_miso`=0, `spi_miso_oe`=0, `tx_hold`=0, state IDLE.
- Pin-to-detect latency: 3 `clk` cycles from an SCK/SS pin change to the internal edge pulse.
- Host constraints:
  - SCK high and low phases ≥ 4 `clk` cycles each (SCK ≤ clk/8; 1.5 MHz at 12 MHz).
  - SS low ≥ 4 `clk` cycles before the first SCK edge.
- `rx_valid` rises 3 `clk` cycles after the 8th SCK rising pin edge; `rx_data` is valid in the same cycle.
- MISO changes 3 `clk` cycles after the SCK falling pin edge, or after the SS falling pin edge. It is therefore stable at the host's next rising edge.
- `tx_empty` rises in the cycle after a load. `we`/`rd` take effect in the next cycle.

## Test plan
- Reset, then idle: all outputs at reset values; SCK toggling with SS high changes nothing.
- Mode 0, `we` 8'hA5, host sends 8'h3C: host receives 8'hA5; `rx_data`=8'h3C, `rx_valid`=1, `tx_empty`=1.
- Mode 3 (SCK idle high), 2-byte burst, `tx_hold` refilled with 8'h81 after the first load:
  - host sends 8'h12, 8'h34; host receives 8'h5A, 8'h81.
  - CPU `rd` after each byte; `overrun` stays 0.
- No TX write, host sends 8'hF0 then 8'h0F without `rd`:
  - host receives 8'hFF twice.
  - `rx_data`=8'h0F, `overrun`=1; one `rd` clears both flags.
- SS deasserted after 5 bits:
  - `rx_valid` stays 0; `busy` falls.
  - the next full transfer of 8'h77 is received correctly with `bit_cnt` restarted.
- `rd` coincident with a byte completion, and `we` coincident with a byte-boundary load:
  - `rx_valid` stays 1, `overrun` stays 0.
  - the written byte appears in the following byte, and `tx_empty`=0 until it is loaded.

Source files
------------

// File: rtl/spi_target.sv
// spi_target
// SPI target (slave) peripheral for the FemtoRV32 memory bus. An external SPI
// host clocks bytes in on MOSI while this block returns CPU-supplied bytes on
// MISO, MSB first. All SPI pins are oversampled with the system clock, so no
// logic runs in the SPI clock domain.
//
// Ports:
//   i_clk          system clock, all logic on its rising edge
//   i_reset        synchronous, active-high reset
//   i_we           one-cycle strobe: load i_tx_data into the TX holding register
//   i_tx_data      byte to send to the host
//   i_rd           one-cycle strobe: CPU consumed o_rx_data
//   o_rx_data      last complete byte received
//   o_rx_valid     o_rx_data holds an unread byte
//   o_overrun      sticky: a byte completed while o_rx_valid was already set
//   o_tx_empty     TX holding register is free
//   o_busy         chip select is active (transfer in progress)
//   i_spi_clk      host SCK (asynchronous)
//   i_spi_ss       host chip select, active low (asynchronous)
//   i_spi_mosi     host data out (asynchronous)
//   o_spi_miso     data to host
//   o_spi_miso_oe  MISO output enable, equal to o_busy

module spi_target #(
  parameter logic [7:0] IDLE_FILL = 8'hFF
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_we,
  input  logic [7:0] i_tx_data,
  input  logic       i_rd,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_overrun,
  output logic       o_tx_empty,
  output logic       o_busy,
  input  logic       i_spi_clk,
  input  logic       i_spi_ss,
  input  logic       i_spi_mosi,
  output logic       o_spi_miso,
  output logic       o_spi_miso_oe
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_sck_s1, r_sck_s2, r_sck_d;
  logic        r_ss_s1, r_ss_s2, r_ss_d;
  logic        r_mosi_s1, r_mosi_s2;

  logic [2:0]  r_bit_cnt;
  logic [6:0]  r_rx_shift;
  logic [7:0]  r_tx_shift;
  logic [7:0]  r_tx_hold;
  logic        r_tx_empty;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_overrun;

  logic        w_sck_rise;
  logic        w_sck_fall;
  logic        w_ss_fall;
  logic        w_enter;
  logic        w_leave;
  logic        w_shift_in;
  logic        w_shift_out;
  logic        w_byte_done;
  logic        w_load;
  logic [7:0]  w_load_byte;
  logic        w_busy;

  // Two-flop synchronizers on all three pins. MOSI goes through the same
  // depth as SCK so the sampled data bit lines up with its detected edge.
  // The SCK/SS history flops give one-cycle edge pulses.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sck_s1  <= 1'b0;
      r_sck_s2  <= 1'b0;
      r_sck_d   <= 1'b0;
      r_ss_s1   <= 1'b1;
      r_ss_s2   <= 1'b1;
      r_ss_d    <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_sck_s1  <= i_spi_clk;
      r_sck_s2  <= r_sck_s1;
      r_sck_d   <= r_sck_s2;
      r_ss_s1   <= i_spi_ss;
      r_ss_s2   <= r_ss_s1;
      r_ss_d    <= r_ss_s2;
      r_mosi_s1 <= i_spi_mosi;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  assign w_sck_rise = r_sck_s2 & ~r_sck_d;
  assign w_sck_fall = ~r_sck_s2 & r_sck_d;
  assign w_ss_fall  = ~r_ss_s2 & r_ss_d;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and per-cycle control strobes. A falling SCK edge while the
  // bit counter is 0 is ignored: in mode 0 it is the trailing edge of the
  // previous byte, in mode 3 it is the host's launch edge of the first bit.
  // Either way the freshly loaded byte must stay in place.
  always_comb begin
    w_next_state = r_state;
    w_enter      = 1'b0;
    w_leave      = 1'b0;
    w_shift_in   = 1'b0;
    w_shift_out  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ss_fall) begin
          w_next_state = ST_ACTIVE;
          w_enter      = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (r_ss_s2) begin
          w_next_state = ST_IDLE;
          w_leave      = 1'b1;
        end else begin
          w_shift_in  = w_sck_rise;
          w_shift_out = w_sck_fall & (r_bit_cnt != 3'd0);
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign w_byte_done = w_shift_in & (r_bit_cnt == 3'd7);
  assign w_load      = w_enter | w_byte_done;
  assign w_load_byte = r_tx_empty ? IDLE_FILL : r_tx_hold;

  // Shift datapath. The TX shift register is reloaded at transfer start and
  // at every byte boundary; the load always sees the holding register as it
  // was before any CPU write in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bit_cnt  <= 3'd0;
      r_rx_shift <= 7'd0;
      r_tx_shift <= 8'd0;
    end else begin
      if (w_enter || w_leave) begin
        r_bit_cnt <= 3'd0;
      end else if (w_shift_in) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end

      if (w_shift_in) begin
        r_rx_shift <= {r_rx_shift[5:0], r_mosi_s2};
      end

      if (w_load) begin
        r_tx_shift <= w_load_byte;
      end else if (w_shift_out) begin
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end
    end
  end

  // TX holding register. A CPU write wins over the load's "now empty" so a
  // byte written during a load is kept for the following byte.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tx_hold  <= 8'd0;
      r_tx_empty <= 1'b1;
    end else begin
      if (i_we) begin
        r_tx_hold  <= i_tx_data;
        r_tx_empty <= 1'b0;
      end else if (w_load) begin
        r_tx_empty <= 1'b1;
      end
    end
  end

  // RX result and status flags. A completing byte takes priority over a CPU
  // read in the same cycle; a read that coincides with completion only
  // suppresses the overrun it would otherwise cause.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rx_data  <= 8'd0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_byte_done) begin
        r_rx_data  <= {r_rx_shift, r_mosi_s2};
        r_rx_valid <= 1'b1;
        if (r_rx_valid && !i_rd) begin
          r_overrun <= 1'b1;
        end
      end else if (i_rd) begin
        r_rx_valid <= 1'b0;
        r_overrun  <= 1'b0;
      end
    end
  end

  assign w_busy        = (r_state == ST_ACTIVE);
  assign o_busy        = w_busy;
  assign o_spi_miso_oe = w_busy;
  assign o_spi_miso    = w_busy & r_tx_shift[7];
  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_overrun     = r_overrun;
  assign o_tx_empty    = r_tx_empty;

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target
// Bench for spi_target. A bit-banged SPI host (modes 0 and 3) drives the pins
// with SCK phases of 5 system clocks; a byte-level model of the peripheral
// (TX holding slot, RX byte and flags) predicts every byte the host receives
// and every status flag the CPU sees.

module tb_spi_target;

  logic       clk = 1'b0;
  logic       reset;
  logic       we;
  logic [7:0] txData;
  logic       rd;
  logic [7:0] rxData;
  logic       rxValid;
  logic       overrun;
  logic       txEmpty;
  logic       busy;
  logic       spiClk;
  logic       spiSs;
  logic       spiMosi;
  logic       spiMiso;
  logic       spiMisoOe;

  int checks   = 0;
  int failures = 0;

  // Reference model state: a one-deep TX slot, the byte currently being
  // shifted out to the host, and the CPU-visible RX byte and flags.
  logic [7:0] mTxHold;
  bit         mTxPending;
  logic [7:0] mCurTx;
  logic [7:0] mRxData;
  bit         mRxValid;
  bit         mOverrun;
  bit         mode3;

  spi_target dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_we          (we),
    .i_tx_data     (txData),
    .i_rd          (rd),
    .o_rx_data     (rxData),
    .o_rx_valid    (rxValid),
    .o_overrun     (overrun),
    .o_tx_empty    (txEmpty),
    .o_busy        (busy),
    .i_spi_clk     (spiClk),
    .i_spi_ss      (spiSs),
    .i_spi_mosi    (spiMosi),
    .o_spi_miso    (spiMiso),
    .o_spi_miso_oe (spiMisoOe)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the edge.
  task automatic waitClks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkFlags(input string tag);
    checkOutput({tag, ".rx_data"},  rxData,           mRxData);
    checkOutput({tag, ".rx_valid"}, {7'd0, rxValid},  {7'd0, mRxValid});
    checkOutput({tag, ".overrun"},  {7'd0, overrun},  {7'd0, mOverrun});
    checkOutput({tag, ".tx_empty"}, {7'd0, txEmpty},  {7'd0, !mTxPending});
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".busy"},    {7'd0, busy},      8'd0);
    checkOutput({tag, ".miso_oe"}, {7'd0, spiMisoOe}, 8'd0);
    checkOutput({tag, ".miso"},    {7'd0, spiMiso},   8'd0);
  endtask

  // Byte that the next transfer slot will carry: the pending CPU byte if
  // there is one, otherwise the fill byte; taking it frees the slot.
  function automatic logic [7:0] modelLoad();
    logic [7:0] b;
    b = mTxPending ? mTxHold : 8'hFF;
    mTxPending = 1'b0;
    return b;
  endfunction

  task automatic cpuWrite(input logic [7:0] d);
    txData = d;
    we = 1'b1;
    waitClks(1);
    we = 1'b0;
    mTxHold = d;
    mTxPending = 1'b1;
  endtask

  task automatic cpuRead();
    rd = 1'b1;
    waitClks(1);
    rd = 1'b0;
    mRxValid = 1'b0;
    mOverrun = 1'b0;
  endtask

  task automatic setIdleClock(input bit m3);
    mode3 = m3;
    spiClk = m3;
    waitClks(5);
  endtask

  task automatic ssLow(input string tag);
    spiSs = 1'b0;
    waitClks(5);
    mCurTx = modelLoad();
    checkOutput({tag, ".busy"},    {7'd0, busy},      8'd1);
    checkOutput({tag, ".miso_oe"}, {7'd0, spiMisoOe}, 8'd1);
  endtask

  task automatic ssHigh(input string tag);
    waitClks(5);
    spiSs = 1'b1;
    waitClks(5);
    checkIdle(tag);
  endtask

  // Host shifts nBits of mosiB (MSB first). On a full byte the CPU strobes
  // rdAtEnd/weAtEnd can be placed exactly on the cycle the byte completes.
  task automatic applyStimulus(input string tag, input logic [7:0] mosiB, input int nBits,
                               input bit rdAtEnd, input bit weAtEnd, input logic [7:0] weD);
    logic [7:0] got;
    logic [7:0] expected;
    got = 8'd0;
    expected = mCurTx;
    for (int i = 7; i >= 8 - nBits; i--) begin
      if (mode3) spiClk = 1'b0;
      spiMosi = mosiB[i];
      waitClks(5);
      got[i] = spiMiso;
      spiClk = 1'b1;
      if (i == 0 && (rdAtEnd || weAtEnd)) begin
        waitClks(2);
        rd = rdAtEnd;
        we = weAtEnd;
        txData = weD;
        waitClks(1);
        rd = 1'b0;
        we = 1'b0;
        waitClks(2);
      end else begin
        waitClks(5);
      end
      if (!mode3) spiClk = 1'b0;
    end
    if (nBits == 8) begin
      if (mRxValid && !rdAtEnd) mOverrun = 1'b1;
      mRxValid = 1'b1;
      mRxData = mosiB;
      mCurTx = modelLoad();
      if (weAtEnd) begin
        mTxHold = weD;
        mTxPending = 1'b1;
      end
      checkOutput({tag, ".host_rx"}, got, expected);
      checkFlags(tag);
    end
  endtask

  initial begin
    int nBytes;
    bit rdEnd;
    bit weEnd;
    reset   = 1'b1;
    we      = 1'b0;
    rd      = 1'b0;
    txData  = 8'd0;
    spiClk  = 1'b0;
    spiSs   = 1'b1;
    spiMosi = 1'b0;
    mode3   = 1'b0;
    mTxHold = 8'd0;
    mTxPending = 1'b0;
    mCurTx  = 8'hFF;
    mRxData = 8'd0;
    mRxValid = 1'b0;
    mOverrun = 1'b0;
    waitClks(3);
    reset = 1'b0;
    waitClks(1);

    $display("[TB] reset state");
    checkFlags("reset");
    checkIdle("reset");

    $display("[TB] SCK toggling with SS high");
    for (int i = 0; i < 6; i++) begin
      spiMosi = 1'($urandom_range(0, 1));
      spiClk = ~spiClk;
      waitClks(5);
    end
    checkFlags("idle_sck");
    checkIdle("idle_sck");

    $display("[TB] mode 0 single byte");
    setIdleClock(1'b0);
    cpuWrite(8'hA5);
    checkOutput("m0.tx_empty_after_we", {7'd0, txEmpty}, 8'd0);
    ssLow("m0");
    applyStimulus("m0.b0", 8'h3C, 8, 1'b0, 1'b0, 8'h00);
    ssHigh("m0");
    cpuRead();
    checkFlags("m0.after_rd");

    $display("[TB] mode 3 burst");
    setIdleClock(1'b1);
    cpuWrite(8'h5A);
    ssLow("m3");
    cpuWrite(8'h81);
    applyStimulus("m3.b0", 8'h12, 8, 1'b0, 1'b0, 8'h00);
    cpuRead();
    applyStimulus("m3.b1", 8'h34, 8, 1'b0, 1'b0, 8'h00);
    cpuRead();
    checkFlags("m3.after_rd");
    ssHigh("m3");

    $display("[TB] fill bytes and overrun");
    setIdleClock(1'b0);
    ssLow("ovr");
    applyStimulus("ovr.b0", 8'hF0, 8, 1'b0, 1'b0, 8'h00);
    applyStimulus("ovr.b1", 8'h0F, 8, 1'b0, 1'b0, 8'h00);
    ssHigh("ovr");
    cpuRead();
    checkFlags("ovr.after_rd");

    $display("[TB] SS abort after 5 bits");
    ssLow("abort");
    applyStimulus("abort.part", 8'hC9, 5, 1'b0, 1'b0, 8'h00);
    ssHigh("abort");
    checkFlags("abort.flags");
    ssLow("abort2");
    applyStimulus("abort2.b0", 8'h77, 8, 1'b0, 1'b0, 8'h00);
    ssHigh("abort2");
    cpuRead();

    $display("[TB] coincident rd/we at byte boundary");
    cpuWrite(8'hC3);
    ssLow("coin");
    applyStimulus("coin.b0", 8'h11, 8, 1'b0, 1'b0, 8'h00);
    applyStimulus("coin.b1", 8'h22, 8, 1'b1, 1'b1, 8'h96);
    applyStimulus("coin.b2", 8'h33, 8, 1'b0, 1'b0, 8'h00);
    ssHigh("coin");
    cpuRead();

    $display("[TB] randomized frames");
    for (int f = 0; f < 25; f++) begin
      setIdleClock(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) cpuWrite(8'($urandom));
      ssLow($sformatf("rnd%0d", f));
      nBytes = int'($urandom_range(1, 3));
      for (int b = 0; b < nBytes; b++) begin
        if ($urandom_range(0, 2) == 0) cpuWrite(8'($urandom));
        rdEnd = ($urandom_range(0, 3) == 0);
        weEnd = ($urandom_range(0, 3) == 0);
        applyStimulus($sformatf("rnd%0d.b%0d", f, b), 8'($urandom), 8, rdEnd, weEnd, 8'($urandom));
        if ($urandom_range(0, 1) == 1) begin
          cpuRead();
          checkFlags($sformatf("rnd%0d.b%0d.rd", f, b));
        end
      end
      ssHigh($sformatf("rnd%0d", f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
